// File: rtl/eth_header_writer_pkg.sv
// Shared definitions for the egress Ethernet header writer.
//   - IO_QUEUE_STAGE_NUM : module-header stage id used on the NetFPGA stream
//   - ETH_IP / ETH_ARP   : ethertype constants
//   - state_e            : header-writer FSM states
//   - log2               : ceiling log2, used to size port-index fields
package eth_header_writer_pkg;

  localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hff;
  localparam logic [15:0] ETH_IP             = 16'h0800;
  localparam logic [15:0] ETH_ARP            = 16'h0806;

  typedef enum logic [1:0] {
    WAIT_INFO   = 2'd0,
    MODULE_HDRS = 2'd1,
    WORD_SA     = 2'd2,
    PAYLOAD     = 2'd3
  } state_e;

  // Smallest n with 2**n >= value.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_header_writer.sv
// Egress Ethernet header writer.
// Rewrites MAC DA with the next-hop MAC and MAC SA with the MAC of the
// selected output port, on the 64-bit NetFPGA data/ctrl stream. One info
// entry is consumed per packet from the output-port lookup's info FIFO.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr      : input stream; in_rdy back-pressures it
//   out_data/out_ctrl/out_wr   : output stream, registered (1-cycle latency)
//   out_rdy                    : downstream ready
//   hdr_info_vld/..._rewrite   : per-packet info (FIFO head)
//   hdr_info_rd                : one-cycle FIFO pop pulse
//   mac_0..mac_3               : MACs of ports 0..3 (queues 0,2,4,6)
//   pkt_rewritten              : pulses with the SA word of a rewritten packet
module eth_header_writer
  import eth_header_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned CTRL_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned NUM_QUEUES       = 8,
  parameter int unsigned NUM_QUEUES_WIDTH = log2(NUM_QUEUES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [CTRL_WIDTH-1:0]       in_ctrl,
  input  logic                        in_wr,
  output logic                        in_rdy,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [CTRL_WIDTH-1:0]       out_ctrl,
  output logic                        out_wr,
  input  logic                        out_rdy,
  input  logic                        hdr_info_vld,
  input  logic [47:0]                 hdr_next_hop_mac,
  input  logic [NUM_QUEUES_WIDTH-1:0] hdr_out_port,
  input  logic                        hdr_rewrite,
  output logic                        hdr_info_rd,
  input  logic [47:0]                 mac_0,
  input  logic [47:0]                 mac_1,
  input  logic [47:0]                 mac_2,
  input  logic [47:0]                 mac_3,
  output logic                        pkt_rewritten
);

  state_e                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]       out_ctrl_q, out_ctrl_d;
  logic                        out_wr_q, out_wr_d;
  logic                        hdr_info_rd_q, hdr_info_rd_d;
  logic                        pkt_rewritten_q, pkt_rewritten_d;
  logic [47:0]                 next_hop_q, next_hop_d;
  logic [NUM_QUEUES_WIDTH-2:0] mac_idx_q, mac_idx_d;
  logic                        do_rw_q, do_rw_d;

  logic [NUM_QUEUES_WIDTH-2:0] info_idx;
  logic [47:0]                 sel_mac;
  logic                        accept;

  assign in_rdy   = out_rdy && (state_q != WAIT_INFO);
  assign accept   = in_wr && in_rdy;
  // Even queues are MAC ports; the upper bits of the queue index pick the port.
  assign info_idx = hdr_out_port[NUM_QUEUES_WIDTH-1:1];

  always_comb begin
    sel_mac = '0;
    case (32'(mac_idx_q))
      32'd0:   sel_mac = mac_0;
      32'd1:   sel_mac = mac_1;
      32'd2:   sel_mac = mac_2;
      32'd3:   sel_mac = mac_3;
      default: sel_mac = '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    out_data_d      = out_data_q;
    out_ctrl_d      = out_ctrl_q;
    out_wr_d        = accept;
    hdr_info_rd_d   = 1'b0;
    pkt_rewritten_d = 1'b0;
    next_hop_d      = next_hop_q;
    mac_idx_d       = mac_idx_q;
    do_rw_d         = do_rw_q;

    if (accept) begin
      out_data_d = in_data;
      out_ctrl_d = in_ctrl;
    end

    case (state_q)
      WAIT_INFO: begin
        // The pop lands one cycle after the entry is latched; the FIFO head
        // is not looked at again until at least two words later.
        if (hdr_info_vld) begin
          next_hop_d    = hdr_next_hop_mac;
          mac_idx_d     = info_idx;
          do_rw_d       = hdr_rewrite && !hdr_out_port[0] && (32'(info_idx) < 32'd4);
          hdr_info_rd_d = 1'b1;
          state_d       = MODULE_HDRS;
        end
      end
      MODULE_HDRS: begin
        if (accept && (in_ctrl == '0)) begin
          if (do_rw_q) out_data_d = {next_hop_q, sel_mac[47:32]};
          state_d = WORD_SA;
        end
      end
      WORD_SA: begin
        if (accept) begin
          if (do_rw_q) begin
            out_data_d      = {sel_mac[31:0], in_data[31:0]};
            pkt_rewritten_d = 1'b1;
          end
          state_d = (in_ctrl != '0) ? WAIT_INFO : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept && (in_ctrl != '0)) state_d = WAIT_INFO;
      end
      default: state_d = WAIT_INFO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT_INFO;
      out_data_q      <= '0;
      out_ctrl_q      <= '0;
      out_wr_q        <= 1'b0;
      hdr_info_rd_q   <= 1'b0;
      pkt_rewritten_q <= 1'b0;
      next_hop_q      <= '0;
      mac_idx_q       <= '0;
      do_rw_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_data_q      <= out_data_d;
      out_ctrl_q      <= out_ctrl_d;
      out_wr_q        <= out_wr_d;
      hdr_info_rd_q   <= hdr_info_rd_d;
      pkt_rewritten_q <= pkt_rewritten_d;
      next_hop_q      <= next_hop_d;
      mac_idx_q       <= mac_idx_d;
      do_rw_q         <= do_rw_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_ctrl      = out_ctrl_q;
  assign out_wr        = out_wr_q;
  assign hdr_info_rd   = hdr_info_rd_q;
  assign pkt_rewritten = pkt_rewritten_q;

  // Writing while not ready is a protocol error; the word is dropped.
  wr_when_not_ready: assert property (@(posedge clk) disable iff (reset) !(in_wr && !in_rdy))
    else $error("eth_header_writer: in_wr asserted while in_rdy=0");

endmodule

// File: tb/tb_eth_header_writer.sv
module tb_eth_header_writer;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        hdr_info_vld;
  logic [47:0] hdr_next_hop_mac;
  logic [2:0]  hdr_out_port;
  logic        hdr_rewrite;
  logic        hdr_info_rd;
  logic [47:0] mac_0, mac_1, mac_2, mac_3;
  logic        pkt_rewritten;

  eth_header_writer #(.DATA_WIDTH(64), .NUM_QUEUES(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .hdr_info_vld(hdr_info_vld), .hdr_next_hop_mac(hdr_next_hop_mac),
    .hdr_out_port(hdr_out_port), .hdr_rewrite(hdr_rewrite), .hdr_info_rd(hdr_info_rd),
    .mac_0(mac_0), .mac_1(mac_1), .mac_2(mac_2), .mac_3(mac_3),
    .pkt_rewritten(pkt_rewritten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] nh;
    logic [2:0]  port;
    logic        rewrite;
    logic [63:0] exp1;
    logic [63:0] exp2;
    int unsigned rewr;
  } case_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        prw;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [47:0] nh;
    logic [2:0]  port;
    logic        rewrite;
  } info_t;

  logic [63:0] words [9];
  case_t       cases [5];
  exp_t        exp_q [$];
  info_t       info_q [$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned neg_cyc = 0;
  int unsigned pops    = 0;
  int unsigned prw_cnt = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, neg_cyc);
    end
  endfunction

  function automatic void refresh_info();
    hdr_info_vld = (info_q.size() > 0);
    if (info_q.size() > 0) begin
      hdr_next_hop_mac = info_q[0].nh;
      hdr_out_port     = info_q[0].port;
      hdr_rewrite      = info_q[0].rewrite;
    end else begin
      hdr_next_hop_mac = '0;
      hdr_out_port     = '0;
      hdr_rewrite      = 1'b0;
    end
  endfunction

  function automatic void push_info(input logic [47:0] nh, input logic [2:0] port, input logic rewrite);
    info_t i;
    i.nh = nh; i.port = port; i.rewrite = rewrite;
    info_q.push_back(i);
    refresh_info();
  endfunction

  // One clock: sample all DUT outputs at the falling edge and score them.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    neg_cyc++;
    if (hdr_info_rd) begin
      pops++;
      if (info_q.size() > 0) info_q.delete(0);
      refresh_info();
    end
    if (pkt_rewritten) prw_cnt++;
    if (out_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_data, 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("pkt_rewritten", 64'(pkt_rewritten), 64'(e.prw));
        chk("latency", 64'(neg_cyc), 64'(e.cyc + 1));
      end
    end else if (!reset) begin
      chk("prw_idle", 64'(pkt_rewritten), 64'd0);
    end
  endtask

  task automatic send_pkt(input int unsigned ci, input int unsigned n, input bit rnd, input bit eop);
    int unsigned i, guard;
    exp_t e;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      tick();
      out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!out_rdy) chk("in_rdy_backpressure", 64'(in_rdy), 64'd0);
      if (in_rdy) begin
        in_wr   = 1'b1;
        in_data = words[i];
        in_ctrl = (i == 0) ? 8'hFF : ((eop && i == n - 1) ? 8'h80 : 8'h00);
        e.d   = (i == 1) ? cases[ci].exp1 : ((i == 2) ? cases[ci].exp2 : words[i]);
        e.c   = in_ctrl;
        e.prw = (i == 2) && (cases[ci].rewr != 0);
        e.cyc = neg_cyc;
        exp_q.push_back(e);
        i++;
      end else begin
        in_wr = 1'b0;
      end
      guard++;
    end
    if (i < n) chk("send_timeout", 64'(i), 64'(n));
    tick();
    in_wr   = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_rdy = 1'b1;
  endtask

  task automatic drain();
    repeat (3) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  int unsigned p0, r0;

  initial begin
    words[0] = 64'h0000_0009_0000_0048;
    words[1] = 64'hFFFF_FFFF_FFFF_0A0B;
    words[2] = 64'h0C0D_0E0F_0800_4500;
    words[3] = 64'h0040_0000_4006_1234;
    words[4] = 64'hC0A8_0001_C0A8_0002;
    words[5] = 64'h1111_2222_3333_4444;
    words[6] = 64'h5555_6666_7777_8888;
    words[7] = 64'h9999_AAAA_BBBB_CCCC;
    words[8] = 64'hDDDD_EEEE_FFFF_0000;

    mac_0 = 48'h02AA_BBCC_DD00;
    mac_1 = 48'hCAFE_0000_0001;
    mac_2 = 48'h0244_5566_7788;
    mac_3 = 48'h0266_7788_99AA;

    cases[0] = '{48'h0011_2233_4455, 3'd2, 1'b1, 64'h0011_2233_4455_CAFE, 64'h0000_0001_0800_4500, 1};
    cases[1] = '{48'h0011_2233_4455, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_0A0B, 64'h0C0D_0E0F_0800_4500, 0};
    cases[2] = '{48'h0011_2233_4455, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_0A0B, 64'h0C0D_0E0F_0800_4500, 0};
    cases[3] = '{48'h0011_2233_4455, 3'd6, 1'b1, 64'h0011_2233_4455_0266, 64'h7788_99AA_0800_4500, 1};
    cases[4] = '{48'hA1B2_C3D4_E5F6, 3'd0, 1'b1, 64'hA1B2_C3D4_E5F6_02AA, 64'hBBCC_DD00_0800_4500, 1};

    reset   = 1'b1;
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 1'b1;
    refresh_info();

    // Reset state
    repeat (3) tick();
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_info_rd", 64'(hdr_info_rd), 64'd0);
    chk("rst_pkt_rewritten", 64'(pkt_rewritten), 64'd0);
    reset = 1'b0;
    tick();
    chk("wait_info_in_rdy", 64'(in_rdy), 64'd0);

    // Table-driven packets
    for (int unsigned k = 0; k < 5; k++) begin
      p0 = pops;
      r0 = prw_cnt;
      push_info(cases[k].nh, cases[k].port, cases[k].rewrite);
      send_pkt(k, 9, 1'b0, 1'b1);
      drain();
      chk("pops_per_pkt", 64'(pops - p0), 64'd1);
      chk("rewritten_per_pkt", 64'(prw_cnt - r0), 64'(cases[k].rewr));
    end

    // Back-to-back with random back-pressure, info valid throughout
    p0 = pops;
    r0 = prw_cnt;
    push_info(cases[0].nh, cases[0].port, cases[0].rewrite);
    push_info(cases[1].nh, cases[1].port, cases[1].rewrite);
    push_info(cases[3].nh, cases[3].port, cases[3].rewrite);
    send_pkt(0, 9, 1'b1, 1'b1);
    send_pkt(1, 9, 1'b1, 1'b1);
    send_pkt(3, 9, 1'b1, 1'b1);
    drain();
    chk("b2b_pops", 64'(pops - p0), 64'd3);
    chk("b2b_rewritten", 64'(prw_cnt - r0), 64'd2);

    // Minimum packet: EOP on the SA word, then a normal packet
    p0 = pops;
    r0 = prw_cnt;
    push_info(cases[0].nh, cases[0].port, cases[0].rewrite);
    send_pkt(0, 3, 1'b0, 1'b1);
    push_info(cases[2].nh, cases[2].port, cases[2].rewrite);
    send_pkt(2, 9, 1'b0, 1'b1);
    drain();
    chk("min_pops", 64'(pops - p0), 64'd2);
    chk("min_rewritten", 64'(prw_cnt - r0), 64'd1);

    // Reset in PAYLOAD, then a packet with fresh info
    push_info(cases[0].nh, cases[0].port, cases[0].rewrite);
    send_pkt(0, 5, 1'b0, 1'b0);
    p0 = pops;
    reset = 1'b1;
    tick();
    chk("midrst_out_wr", 64'(out_wr), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    reset = 1'b0;
    #1;
    chk("midrst_in_rdy", 64'(in_rdy), 64'd0);
    tick();
    chk("midrst_no_pop", 64'(pops - p0), 64'd0);
    r0 = prw_cnt;
    push_info(cases[3].nh, cases[3].port, cases[3].rewrite);
    send_pkt(3, 9, 1'b0, 1'b1);
    drain();
    chk("postrst_pops", 64'(pops - p0), 64'd1);
    chk("postrst_rewritten", 64'(prw_cnt - r0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eth_header_writer.md
Name: eth_header_writer

Overview:
Egress-side counterpart of the ingress Ethernet parser. It rewrites the Ethernet header of each outgoing packet on the 64-bit NetFPGA data/ctrl stream. MAC DA is set to the next-hop MAC, and MAC SA is set to the MAC of the selected output port. It sits after the output-port lookup and before the output queues, and consumes one per-packet info entry from the lookup's info FIFO.

Parameters:
DATA_WIDTH, 64, stream data width; fixed at 64.
CTRL_WIDTH, DATA_WIDTH/8, stream ctrl width.
NUM_QUEUES, 8, number of output queues; even indices are MAC ports, odd indices are CPU queues.
NUM_QUEUES_WIDTH, log2(NUM_QUEUES), width of the port index.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  64  input stream data
in_ctrl  in  8  input stream ctrl; nonzero before the first data word = module header; nonzero after = EOP
in_wr  in  1  input word valid; only asserted when in_rdy=1
in_rdy  out  1  block can accept an input word this cycle
out_data  out  64  output stream data
out_ctrl  out  8  output stream ctrl
out_wr  out  1  output word valid
out_rdy  in  1  downstream can accept a word
hdr_info_vld  in  1  per-packet info available (FIFO not empty)
hdr_next_hop_mac  in  48  new MAC DA
hdr_out_port  in  NUM_QUEUES_WIDTH  output queue index
hdr_rewrite  in  1  1 = rewrite header, 0 = pass through
hdr_info_rd  out  1  pop pulse for the info FIFO
mac_0..mac_3  in  48 each  MAC of ports 0..3 (queues 0,2,4,6)
pkt_rewritten  out  1  one-cycle pulse per packet whose header was rewritten

Behaviour:
- Reset: state=WAIT_INFO; out_wr=0, out_data=0, out_ctrl=0, hdr_info_rd=0, pkt_rewritten=0; latched info cleared.
- Word layout: first data word (ctrl=0) = {DA[47:0], SA[47:32]}; second = {SA[31:0], ethertype, ver/ihl/tos}.
- in_rdy = out_rdy && state!=WAIT_INFO (combinational).
- Accepted word = in_wr && in_rdy. An accepted word appears on out_* the next cycle with out_wr=1, otherwise out_wr=0. Latency is exactly 1 cycle.
- State WAIT_INFO: when hdr_info_vld=1:
  - latch next-hop MAC, port and do_rw = hdr_rewrite && !hdr_out_port[0];
  - pulse hdr_info_rd for 1 cycle;
  - go to MODULE_HDRS.
  - This costs one bubble cycle per packet.
- State MODULE_HDRS: accepted words with ctrl!=0 pass unchanged. An accepted word with ctrl==0 is the DA word:
  - if do_rw, output {next_hop_mac, sel_mac[47:32]};
  - go to WORD_SA.
- State WORD_SA: the next accepted word:
  - if do_rw, data[63:32] is replaced by sel_mac[31:0], and pkt_rewritten pulses with this word's out_wr;
  - if its ctrl!=0 (EOP), go to WAIT_INFO; else go to PAYLOAD.
- State PAYLOAD: words pass unchanged. An accepted word with ctrl!=0 is EOP and goes to WAIT_INFO.
- sel_mac selection by hdr_out_port[NUM_QUEUES_WIDTH-1:1]:
  - 0..3 select mac_0..mac_3;
  - any other value forces do_rw=0 (pass through).
- Odd port (CPU queue) or hdr_rewrite=0: the whole packet passes bit-exact; pkt_rewritten stays 0; the info entry is still popped.
- Back-pressure: with out_rdy=0, in_rdy=0 and no word is accepted. The output register holds its value; out_wr=0 after the pending word is presented once.
- in_wr while in_rdy=0 is a protocol error and is ignored. The sim-only check (translate_off) does $display and $stop.
- Reset mid-packet: the packet is discarded; the block returns to WAIT_INFO and does not pop.
- hdr_info_vld staying high across back-to-back packets: exactly one pop per packet.

Decomposition:
- Shared defines header: IO_QUEUE_STAGE_NUM, ETH_IP/ETH_ARP ethertypes, state encodings WAIT_INFO=0, MODULE_HDRS=1, WORD_SA=2, PAYLOAD=3.
- log2 function as in existing blocks.
- No sub-module required; the MAC select mux is an inline always @(*).

Test Plan:
- Packet with 1 module header + 8 data words; info {next_hop=00:11:22:33:44:55, port=2, rewrite=1}; mac_1=CA:FE:00:00:00:01 -> word1 data=0x0011223344 55CAFE, word2[63:32]=0x00000001, other words unchanged, latency 1, one hdr_info_rd pulse, one pkt_rewritten pulse.
- Same packet, port=3 (odd) -> output identical to input, pkt_rewritten=0, hdr_info_rd pulses once.
- hdr_rewrite=0, port=0 -> bit-exact pass-through.
- Random out_rdy toggling (50%) across 3 back-to-back packets -> no loss or duplication, order preserved, 3 pops, in_rdy=0 whenever out_rdy=0.
- Minimum packet with EOP on the SA word -> SA rewritten, return to WAIT_INFO, next packet handled correctly.
- reset asserted during PAYLOAD -> out_wr=0 next cycle, state WAIT_INFO, next packet uses fresh info.
